// File: rtl/fifo_rx.sv
// Receive-side byte FIFO: packs demodulated bits LSB first into bytes, buffers them in a
// circular store and exposes them to the CPU through a zero-wait APB slave.
module fifo_rx #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    paddr,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [7:0]    pwdata,
  output logic [7:0]    prdata,
  output logic          pready,
  output logic          pslverr,
  input  logic          en_IQ,
  input  logic          frame_start,
  input  logic          data_in,
  input  logic          data_valid,
  output logic          irq,
  output logic [AW:0]   mem_state
);

  localparam logic [AW:0]   L_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic          r_ovf;
  logic [7:0]    r_thresh;
  logic          r_irq;

  logic          w_access;
  logic          w_rdAccess;
  logic          w_wrAccess;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_flush;
  logic          w_clrOvf;
  logic          w_threshWr;
  logic          w_byteDone;
  logic [7:0]    w_byte;
  logic          w_pushReq;
  logic          w_push;
  logic          w_overflow;
  logic [AW:0]   w_countNext;

  assign w_access   = psel & penable;
  assign w_rdAccess = w_access & ~pwrite;
  assign w_wrAccess = w_access & pwrite;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == L_FULL);
  assign w_pop      = w_rdAccess & (paddr == 8'h00) & ~w_empty;
  assign w_flush    = w_wrAccess & (paddr == 8'h03) & pwdata[0];
  assign w_clrOvf   = w_wrAccess & (paddr == 8'h03) & pwdata[1];
  assign w_threshWr = w_wrAccess & (paddr == 8'h04);

  // The eighth bit completes the byte in the same edge it arrives, so it bypasses the shifter.
  assign w_byteDone = en_IQ & data_valid & ~frame_start & (r_bitCnt == 3'd7);
  assign w_byte     = {data_in, r_shift[6:0]};
  assign w_pushReq  = w_byteDone & ~w_flush;
  assign w_push     = w_pushReq & (~w_full | w_pop);
  assign w_overflow = w_pushReq & w_full & ~w_pop;

  always_comb begin
    w_countNext = r_count;
    if (w_flush)
      w_countNext = '0;
    else if (w_push && !w_pop)
      w_countNext = r_count + L_CNT_ONE;
    else if (w_pop && !w_push)
      w_countNext = r_count - L_CNT_ONE;
  end

  always_comb begin
    prdata  = 8'h00;
    pslverr = 1'b0;
    if (w_access) begin
      case (paddr)
        8'h00: begin
          if (pwrite || w_empty) pslverr = 1'b1;
          else                   prdata  = r_mem[r_rdPtr];
        end
        8'h01: begin
          if (pwrite) pslverr = 1'b1;
          else        prdata  = {4'b0000, r_irq, r_ovf, w_full, w_empty};
        end
        8'h02: begin
          if (pwrite) pslverr = 1'b1;
          else        prdata  = 8'(r_count);
        end
        8'h03: prdata = 8'h00;
        8'h04: begin
          if (!pwrite) prdata = r_thresh;
        end
        default: pslverr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= w_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bitCnt <= 3'd0;
      r_shift  <= 8'h00;
    end else if (w_flush || !en_IQ) begin
      r_bitCnt <= 3'd0;
      r_shift  <= 8'h00;
    end else if (frame_start) begin
      r_shift  <= {7'b0000000, data_in & data_valid};
      r_bitCnt <= data_valid ? 3'd1 : 3'd0;
    end else if (data_valid) begin
      r_shift[r_bitCnt] <= data_in;
      r_bitCnt          <= r_bitCnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + L_PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + L_PTR_ONE;
      r_count <= w_countNext;
    end
  end

  // A fresh overflow outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ovf    <= 1'b0;
      r_thresh <= 8'h01;
      r_irq    <= 1'b0;
    end else begin
      if (w_overflow)    r_ovf <= 1'b1;
      else if (w_clrOvf) r_ovf <= 1'b0;
      if (w_threshWr) r_thresh <= pwdata;
      r_irq <= (r_thresh != 8'h00) && (int'(w_countNext) >= int'(r_thresh));
    end
  end

  assign pready    = 1'b1;
  assign irq       = r_irq;
  assign mem_state = r_count;

endmodule

// File: tb/tb_fifo_rx.sv
// Self-checking bench for fifo_rx: a byte scoreboard queue for DATA reads, a register
// vector table and hand-written sequences for the multi-cycle corner cases.
module tb_fifo_rx;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [7:0]    pwdata;
  logic [7:0]    prdata;
  logic          pready;
  logic          pslverr;
  logic          en_IQ;
  logic          frame_start;
  logic          data_in;
  logic          data_valid;
  logic          irq;
  logic [AW:0]   mem_state;

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0] expQ[$];

  typedef struct {
    string      name;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] expData;
    logic       expErr;
  } regVec_t;

  regVec_t vecs[13];

  fifo_rx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .en_IQ(en_IQ), .frame_start(frame_start), .data_in(data_in), .data_valid(data_valid),
    .irq(irq), .mem_state(mem_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    frame_start = 1'b0; data_in = 1'b0; data_valid = 1'b0; en_IQ = 1'b1;
    step(); step();
    reset_n = 1'b1;
    expQ.delete();
  endtask

  task automatic sendBit(input logic b);
    en_IQ = 1'b1; data_valid = 1'b1; data_in = b;
    step();
    data_valid = 1'b0; data_in = 1'b0;
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) sendBit(b[i]);
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendBits(b, 8);
    if (expQ.size() < DEPTH) expQ.push_back(b);
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               output logic [7:0] rdata, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    step();
    penable = 1'b1;
    #3;
    rdata = prdata;
    err   = pslverr;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic readData(input string name);
    logic [7:0] d;
    logic       e;
    logic [7:0] exp;
    applyStimulus(1'b0, 8'h00, 8'h00, d, e);
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      checkOutput({name, " data"}, 16'(d), 16'(exp));
      checkOutput({name, " pslverr"}, 16'(e), 16'd0);
    end else begin
      checkOutput({name, " empty data"}, 16'(d), 16'h00);
      checkOutput({name, " empty pslverr"}, 16'(e), 16'd1);
    end
  endtask

  task automatic checkReg(input string name, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    logic       e;
    applyStimulus(1'b0, addr, 8'h00, d, e);
    checkOutput(name, 16'(d), 16'(exp));
    checkOutput({name, " pslverr"}, 16'(e), 16'd0);
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [7:0] wdata);
    logic [7:0] d;
    logic       e;
    applyStimulus(1'b1, addr, wdata, d, e);
    checkOutput("write pslverr", 16'(e), 16'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    logic [7:0] exp;

    vecs[0]  = '{"STATUS one byte",  1'b0, 8'h01, 8'h00, 8'h08, 1'b0};
    vecs[1]  = '{"COUNT one byte",   1'b0, 8'h02, 8'h00, 8'h01, 1'b0};
    vecs[2]  = '{"CTRL read",        1'b0, 8'h03, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{"THRESH default",   1'b0, 8'h04, 8'h00, 8'h01, 1'b0};
    vecs[4]  = '{"write DATA",       1'b1, 8'h00, 8'hFF, 8'h00, 1'b1};
    vecs[5]  = '{"read 0x07",        1'b0, 8'h07, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{"write STATUS",     1'b1, 8'h01, 8'h03, 8'h00, 1'b1};
    vecs[7]  = '{"write COUNT",      1'b1, 8'h02, 8'h07, 8'h00, 1'b1};
    vecs[8]  = '{"read 0x05",        1'b0, 8'h05, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{"write THRESH 2",   1'b1, 8'h04, 8'h02, 8'h00, 1'b0};
    vecs[10] = '{"THRESH readback",  1'b0, 8'h04, 8'h00, 8'h02, 1'b0};
    vecs[11] = '{"STATUS irq off",   1'b0, 8'h01, 8'h00, 8'h00, 1'b0};
    vecs[12] = '{"write THRESH 1",   1'b1, 8'h04, 8'h01, 8'h00, 1'b0};

    // Reset state and first byte assembly
    doReset();
    checkOutput("reset mem_state", 16'(mem_state), 16'd0);
    checkOutput("reset irq", 16'(irq), 16'd0);
    checkOutput("reset prdata", 16'(prdata), 16'd0);
    checkOutput("reset pslverr", 16'(pslverr), 16'd0);
    checkOutput("pready", 16'(pready), 16'd1);
    sendBits(8'h0D, 7);
    checkOutput("7 bits count", 16'(mem_state), 16'd0);
    sendBit(1'b0);
    expQ.push_back(8'h0D);
    checkOutput("8th bit count", 16'(mem_state), 16'd1);
    readData("first byte");
    checkReg("STATUS empty", 8'h01, 8'h01);

    // Fill, overflow, clear overflow, drain past empty
    doReset();
    for (int i = 0; i < DEPTH; i++) sendByte(8'(i));
    sendByte(8'hAA);
    checkOutput("full mem_state", 16'(mem_state), 16'd16);
    checkReg("STATUS full ovf", 8'h01, 8'h0E);
    checkReg("COUNT full", 8'h02, 8'h10);
    writeReg(8'h03, 8'h02);
    checkReg("STATUS ovf cleared", 8'h01, 8'h0A);
    for (int i = 0; i <= DEPTH; i++) readData("drain");
    checkOutput("drained mem_state", 16'(mem_state), 16'd0);

    // Push while full, coincident with a pop
    doReset();
    for (int i = 0; i < DEPTH; i++) sendByte(8'(8'h10 + i));
    sendBits(8'h55, 7);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
    step();
    penable = 1'b1; en_IQ = 1'b1; data_valid = 1'b1; data_in = 1'b0;
    #3;
    d = prdata;
    e = pslverr;
    step();
    psel = 1'b0; penable = 1'b0; data_valid = 1'b0;
    exp = expQ.pop_front();
    checkOutput("full push+pop data", 16'(d), 16'(exp));
    checkOutput("full push+pop pslverr", 16'(e), 16'd0);
    expQ.push_back(8'h55);
    checkOutput("full push+pop count", 16'(mem_state), 16'd16);
    checkReg("STATUS no ovf", 8'h01, 8'h0A);
    for (int i = 0; i < DEPTH; i++) readData("drain after push+pop");

    // Threshold interrupt timing
    doReset();
    writeReg(8'h04, 8'h04);
    for (int i = 0; i < 3; i++) sendByte(8'(8'hC0 + i));
    checkOutput("irq below thresh", 16'(irq), 16'd0);
    sendBits(8'hC3, 7);
    checkOutput("irq before 4th", 16'(irq), 16'd0);
    sendBit(1'b1);
    expQ.push_back(8'hC3);
    checkOutput("count at thresh", 16'(mem_state), 16'd4);
    checkOutput("irq at thresh", 16'(irq), 16'd1);
    readData("thresh pop");
    checkOutput("irq after pop", 16'(irq), 16'd0);
    checkOutput("count after pop", 16'(mem_state), 16'd3);

    // frame_start realignment, then flush
    doReset();
    sendBits(8'hFF, 5);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    sendByte(8'h3C);
    checkOutput("frame_start count", 16'(mem_state), 16'd1);
    sendBits(8'hFF, 3);
    frame_start = 1'b1;
    sendBit(1'b1);
    frame_start = 1'b0;
    for (int i = 1; i < 8; i++) sendBit(i == 7);
    expQ.push_back(8'h81);
    checkOutput("frame_start+bit count", 16'(mem_state), 16'd2);
    readData("realigned byte");
    writeReg(8'h03, 8'h01);
    expQ.delete();
    checkOutput("flush mem_state", 16'(mem_state), 16'd0);
    checkReg("STATUS after flush", 8'h01, 8'h01);
    sendByte(8'h77);
    readData("after flush");

    // Register table with one byte held, then reset and en_IQ mid-byte
    doReset();
    sendByte(8'h5A);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, e);
      checkOutput({vecs[i].name, " prdata"}, 16'(d), 16'(vecs[i].expData));
      checkOutput({vecs[i].name, " pslverr"}, 16'(e), 16'(vecs[i].expErr));
    end
    checkOutput("count after errors", 16'(mem_state), 16'd1);
    readData("after errors");
    sendBits(8'hFF, 3);
    doReset();
    sendByte(8'h96);
    readData("after mid-byte reset");
    sendBits(8'hFF, 4);
    en_IQ = 1'b0;
    data_valid = 1'b1; data_in = 1'b1;
    step();
    data_valid = 1'b0;
    en_IQ = 1'b1;
    sendByte(8'h21);
    checkOutput("en_IQ drop count", 16'(mem_state), 16'd1);
    readData("after en_IQ drop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
